// File: rtl/j1_mem_arbiter.sv
// J1 data-port arbiter: CPU owns the RAM port, host steals a cycle
// after a bounded wait or halts the CPU for bulk access.
module j1_mem_arbiter #(
  parameter int AW       = 13,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          resetq,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_hold,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_halt,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          halted,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

  state_t        state;
  logic [7:0]    wait_cnt;
  logic [DW-1:0] rdata_q;
  logic          cpu_act;
  logic          steal;

  assign cpu_act = cpu_rd | cpu_wr;
  assign steal   = (wait_cnt == LAST);
  assign halted  = (state == HALT);

  always_comb begin
    host_gnt = 1'b0;
    cpu_hold = 1'b0;
    unique case (1'b1)
      halted: begin
        host_gnt = host_req;
        cpu_hold = 1'b1;
      end
      default: begin
        host_gnt = host_req & (~cpu_act | steal);
        cpu_hold = host_gnt & cpu_act;
      end
    endcase
  end

  // CPU ports are the idle default; a held CPU never writes
  assign mem_addr  = host_gnt ? host_addr  : cpu_addr;
  assign mem_wdata = host_gnt ? host_wdata : cpu_wdata;
  assign mem_we    = host_gnt ? host_we    : (cpu_wr & ~cpu_hold);

  assign cpu_rdata  = mem_rdata;
  assign host_rdata = host_rvalid ? mem_rdata : rdata_q;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state       <= RUN;
      wait_cnt    <= '0;
      host_rvalid <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state <= host_halt ? HALT : RUN;
      if (!host_req || host_gnt)
        wait_cnt <= '0;
      else if (wait_cnt != LAST)
        wait_cnt <= wait_cnt + 8'd1;
      host_rvalid <= host_gnt & ~host_we;
      // keep the last host read word visible after the pulse
      if (host_rvalid)
        rdata_q <= mem_rdata;
    end
  end

endmodule

// File: doc/j1_mem_arbiter.md
Name: j1_mem_arbiter

Overview:
- Shares the J1 data-side port of the 16-bit program/data RAM between two requesters: the J1 core and a host loader/debug port (UART- or SPI-driven).
- The CPU normally owns the port. A waiting host is guaranteed service by stealing one cycle, and the host can halt the CPU to bulk-load code.
- The block sits between the j1 core data signals and the RAM's data read/write port. The instruction-fetch port is untouched.

Parameters:
- AW, 13, RAM word-address width.
- DW, 16, data width.
- MAX_WAIT, 8, consecutive blocked host-request cycles before a forced steal (range 1..255).

Ports:
- clk  in  1  system clock
- resetq  in  1  asynchronous active-low reset
- cpu_rd  in  1  CPU data read request this cycle
- cpu_wr  in  1  CPU data write request this cycle
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  DW  CPU write data
- cpu_hold  out  1  freezes CPU (clock-enable low); CPU must hold its request stable
- cpu_rdata  out  DW  read data to CPU (mem_rdata passthrough)
- host_req  in  1  host access request, held until host_gnt
- host_we  in  1  1=write, 0=read
- host_addr  in  AW  host word address
- host_wdata  in  DW  host write data
- host_halt  in  1  level: request CPU halt
- host_gnt  out  1  host access performed this cycle
- host_rvalid  out  1  host read data valid (1-cycle pulse)
- host_rdata  out  DW  host read data
- halted  out  1  CPU is in halt state
- mem_addr  out  AW  RAM data-port address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, registered, 1-cycle latency

Behaviour:
- Reset (resetq low, async): state=RUN, wait_cnt=0, host_rvalid=0, host_rdata=0, halted=0. Combinational outputs then follow the RUN rules below.
- cpu_act = cpu_rd | cpu_wr. One RAM access per cycle.
- RUN state:
  - host_gnt = host_req & (!cpu_act | wait_cnt==MAX_WAIT-1).
  - cpu_hold = host_gnt & cpu_act (steal cycle). Otherwise cpu_hold=0.
  - The owner drives mem_addr/mem_we/mem_wdata. When idle, mem_addr=cpu_addr and mem_we=0.
  - mem_we = host_gnt ? host_we : (cpu_wr & !cpu_hold).
- wait_cnt (8-bit):
  - Cleared when !host_req or host_gnt.
  - Incremented when host_req & !host_gnt.
  - Never exceeds MAX_WAIT-1.
- HALT state:
  - halted=1 and cpu_hold=1 every cycle.
  - host_gnt = host_req. CPU requests are ignored; mem_we = host_gnt & host_we.
- Transitions:
  - RUN->HALT on the clock edge where host_halt=1. The cycle of that edge still arbitrates under RUN rules.
  - HALT->RUN on the edge where host_halt=0. cpu_hold drops in the first RUN cycle.
  - host_halt raised during a steal cycle: the steal completes normally, then HALT.
- Host read returns:
  - Grant of a read at cycle N gives host_rvalid=1 at N+1, with host_rdata registered from mem_rdata at the N+1 edge (held until the next host read).
  - host_rvalid=1 at N+1 and N+2 when reads are granted back-to-back.
- cpu_rdata = mem_rdata always. The CPU ignores it in the cycle following a steal or host access, because a held CPU re-issues its request.
- Host write and CPU write to the same address in different cycles are ordered by grant order. No merging.
- Reset mid-HALT or mid-steal: immediate return to RUN, cpu_hold=0, pending host request ungranted until re-arbitrated.
- MAX_WAIT=1: any contended host request steals on its first cycle.

Test Plan:
- Reset, CPU idle, host read addr 0x0040 (RAM holds 0x1234) -> host_gnt same cycle, cpu_hold=0, host_rvalid=1 next cycle with host_rdata=0x1234.
- CPU cpu_rd every cycle, host_req write 0x0100<=0xBEEF, MAX_WAIT=8 -> host_gnt exactly 7 cycles after request (8th cycle), cpu_hold=1 that cycle only, mem_we=1, mem_addr=0x0100, then wait_cnt=0.
- CPU write 0x0010<=0x5555 with host idle -> mem_we=1, mem_addr=0x0010, mem_wdata=0x5555, cpu_hold=0, host_gnt=0.
- host_halt=1, then 16 consecutive host writes 0x0000..0x000F -> halted=1 and cpu_hold=1 from next cycle, 16 grants in 16 cycles, CPU requests produce no mem_we; drop host_halt -> halted=0 next cycle, CPU writes resume.
- host_halt raised in the steal cycle -> steal write completes (single mem_we), halted=1 the following cycle.
- Assert resetq=0 while halted with host_req=1 -> halted=0, cpu_hold=0, host_rvalid=0 asynchronously; after release, request re-arbitrated in RUN.
